// File: rtl/div_pkg.sv
// Shared divider package.
//   DIV_WIDTH   : default datapath / Dbus width
//   wb_state_t  : writeback FSM states
//   apply_sign  : magnitude + sign -> two's complement, shared with the
//                 dividend/divisor load units (which strip signs the same way)
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CORRECT = 3'd1,
    REQ_Q   = 3'd2,
    DRV_Q   = 3'd3,
    REQ_R   = 3'd4,
    DRV_R   = 3'd5,
    DONE    = 3'd6
  } wb_state_t;

  // Negation is its own inverse mod 2^W, so the same helper serves both
  // the strip (load side) and restore (writeback side) directions.
  function automatic logic [DIV_WIDTH-1:0] apply_sign(input logic [DIV_WIDTH-1:0] mag,
                                                      input logic                 sign);
    return sign ? (~mag + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : mag;
  endfunction

endpackage

// File: rtl/quotient_writeback_if.sv
// Dbus handshake between the quotient writeback block and the bus arbiter.
//   bus_req   : request to arbiter
//   bus_grant : arbiter grant
//   bus_oe    : Dbus_out valid / drive enable
//   Dbus_out  : data driven to Dbus
interface quotient_writeback_if #(
  parameter int WIDTH = 16
) ();
  logic             bus_req;
  logic             bus_grant;
  logic             bus_oe;
  logic [WIDTH-1:0] Dbus_out;

  modport master (output bus_req, output bus_oe, output Dbus_out, input bus_grant);
  modport slave  (input bus_req, input bus_oe, input Dbus_out, output bus_grant);
endinterface

// File: rtl/sign_restore.sv
// Combinational magnitude + sign -> two's-complement result.
//   mag  : unsigned magnitude
//   sign : 1 = result is negative
//   val  : two's-complement value (mod 2^WIDTH; -0 stays 0)
//   ovf  : value not representable as a signed WIDTH-bit number
module sign_restore #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] mag,
  input  logic             sign,
  output logic [WIDTH-1:0] val,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  assign val = sign ? (~mag + ONE) : mag;
  // Positive range tops out at 2^(W-1)-1; negative range reaches 2^(W-1).
  assign ovf = sign ? (mag > MIN_MAG) : mag[WIDTH-1];
endmodule

// File: rtl/quotient_writeback.sv
// Output end of the signed divider: restores signs on quotient/remainder
// magnitudes, flags overflow / divide-by-zero, then writes quotient and
// remainder onto the shared Dbus through the arbiter handshake.
//   clk, rst          : clock, async active-high reset
//   start             : 1-cycle pulse, magnitudes valid (ignored while busy)
//   q_mag, r_mag      : unsigned quotient / remainder magnitudes
//   dividend_sign     : sign of original dividend
//   divisor_sign      : sign of original divisor
//   div_by_zero       : divisor was zero (sampled with start)
//   bus               : Dbus handshake (master side)
//   busy              : high in every state except IDLE
//   done              : 1-cycle completion pulse
//   overflow, error   : sticky until next accepted start
module quotient_writeback
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     q_mag,
  input  logic [WIDTH-1:0]     r_mag,
  input  logic                 dividend_sign,
  input  logic                 divisor_sign,
  input  logic                 div_by_zero,
  quotient_writeback_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 error
);
  wb_state_t        state_q, state_d;
  logic [WIDTH-1:0] q_mag_q, q_mag_d, r_mag_q, r_mag_d;
  logic             dsign_q, dsign_d, vsign_q, vsign_d, dbz_q, dbz_d;
  logic             bus_req_q, bus_req_d, bus_oe_q, bus_oe_d;
  logic [WIDTH-1:0] dbus_q, dbus_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ovf_q, ovf_d, err_q, err_d;

  logic [WIDTH-1:0] q_val, r_val;
  logic             q_ovf, r_ovf_unused;

  sign_restore #(.WIDTH(WIDTH)) u_q_restore (
    .mag (q_mag_q),
    .sign(dsign_q ^ vsign_q),
    .val (q_val),
    .ovf (q_ovf)
  );

  // Remainder takes the dividend's sign and can never overflow.
  sign_restore #(.WIDTH(WIDTH)) u_r_restore (
    .mag (r_mag_q),
    .sign(dsign_q),
    .val (r_val),
    .ovf (r_ovf_unused)
  );

  always_comb begin
    state_d   = state_q;
    q_mag_d   = q_mag_q;
    r_mag_d   = r_mag_q;
    dsign_d   = dsign_q;
    vsign_d   = vsign_q;
    dbz_d     = dbz_q;
    bus_req_d = 1'b0;
    bus_oe_d  = 1'b0;
    dbus_d    = '0;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        q_mag_d = q_mag;
        r_mag_d = r_mag;
        dsign_d = dividend_sign;
        vsign_d = divisor_sign;
        dbz_d   = div_by_zero;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        state_d = CORRECT;
      end
      CORRECT: if (dbz_q) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        ovf_d     = q_ovf;
        bus_req_d = 1'b1;
        state_d   = REQ_Q;
      end
      REQ_Q: if (bus.bus_grant) begin
        bus_oe_d = 1'b1;
        dbus_d   = q_val;   // wrapped value still goes out on overflow
        state_d  = DRV_Q;
      end else begin
        bus_req_d = 1'b1;
      end
      DRV_Q: begin
        bus_req_d = 1'b1;
        state_d   = REQ_R;
      end
      REQ_R: if (bus.bus_grant) begin
        bus_oe_d = 1'b1;
        dbus_d   = r_val;
        state_d  = DRV_R;
      end else begin
        bus_req_d = 1'b1;
      end
      DRV_R: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_mag_q   <= '0;
      r_mag_q   <= '0;
      dsign_q   <= 1'b0;
      vsign_q   <= 1'b0;
      dbz_q     <= 1'b0;
      bus_req_q <= 1'b0;
      bus_oe_q  <= 1'b0;
      dbus_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_mag_q   <= q_mag_d;
      r_mag_q   <= r_mag_d;
      dsign_q   <= dsign_d;
      vsign_q   <= vsign_d;
      dbz_q     <= dbz_d;
      bus_req_q <= bus_req_d;
      bus_oe_q  <= bus_oe_d;
      dbus_q    <= dbus_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign bus.bus_req  = bus_req_q;
  assign bus.bus_oe   = bus_oe_q;
  assign bus.Dbus_out = dbus_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign error        = err_q;
endmodule
